// File: rtl/mux_32_to_1.sv
// Single-bit 32:1 selector: Y = X[S] through a 5-level 2:1 mux tree, plus a registered copy.
// Y is zero-latency; Y_q/valid_q follow one cycle after an en=1 edge; no backpressure, en/valid only.
module mux_32_to_1 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] X,
  input  logic [4:0]  S,
  input  logic        en,
  output logic        Y,
  output logic        Y_q,
  output logic        valid_q
);

  logic [15:0] lvl0;
  logic [7:0]  lvl1;
  logic [3:0]  lvl2;
  logic [1:0]  lvl3;

  // Each level halves the candidates; cell k takes pair (2k, 2k+1) from the level below.
  genvar k;
  generate
    for (k = 0; k < 16; k++) begin : g_lvl0
      assign lvl0[k] = S[0] ? X[2*k+1] : X[2*k];
    end
    for (k = 0; k < 8; k++) begin : g_lvl1
      assign lvl1[k] = S[1] ? lvl0[2*k+1] : lvl0[2*k];
    end
    for (k = 0; k < 4; k++) begin : g_lvl2
      assign lvl2[k] = S[2] ? lvl1[2*k+1] : lvl1[2*k];
    end
    for (k = 0; k < 2; k++) begin : g_lvl3
      assign lvl3[k] = S[3] ? lvl2[2*k+1] : lvl2[2*k];
    end
  endgenerate

  assign Y = S[4] ? lvl3[1] : lvl3[0];

  // valid_q marks a fresh capture only; Y_q holds across en=0 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= en;
      if (en) begin
        Y_q <= Y;
      end
    end
  end

endmodule

// File: tb/tb_mux_32_to_1.sv
// Self-checking bench for mux_32_to_1 against a shift-and-mask reference model.
module tb_mux_32_to_1;

  logic        clk;
  logic        rst_n;
  logic [31:0] X;
  logic [4:0]  S;
  logic        en;
  logic        Y;
  logic        Y_q;
  logic        valid_q;

  int asserts;
  int fails;

  mux_32_to_1 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .X       (X),
    .S       (S),
    .en      (en),
    .Y       (Y),
    .Y_q     (Y_q),
    .valid_q (valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_sel(input logic [31:0] x, input int s);
    logic [31:0] sh;
    sh = x >> s;
    return sh[0];
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; X = 32'h0; S = 5'd0;
    #2;
    asserts++;
    if (Y_q !== 1'b0) begin fails++; $display("FAIL reset_yq: got %b expected 0", Y_q); end
    asserts++;
    if (valid_q !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", valid_q); end
  endtask

  task automatic test_alternating;
    X = 32'hAAAAAAAA;
    for (int s = 0; s < 32; s++) begin
      S = s[4:0];
      #10;
      asserts++;
      if (Y !== ((s % 2) == 1)) begin
        fails++; $display("FAIL alternating S=%0d: got %b expected %b", s, Y, (s % 2) == 1);
      end
    end
  endtask

  task automatic test_walking_one;
    for (int i = 0; i < 32; i++) begin
      X = 32'h1 << i;
      for (int s = 0; s < 32; s++) begin
        S = s[4:0];
        #1;
        asserts++;
        if (Y !== (s == i)) begin
          fails++; $display("FAIL walking_one i=%0d S=%0d: got %b expected %b", i, s, Y, s == i);
        end
      end
    end
  endtask

  task automatic test_boundary;
    int codes [4] = '{0, 31, 1, 30};
    logic exp [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    X = 32'h80000001;
    for (int j = 0; j < 4; j++) begin
      S = codes[j][4:0];
      #1;
      asserts++;
      if (Y !== exp[j]) begin
        fails++; $display("FAIL boundary S=%0d: got %b expected %b", codes[j], Y, exp[j]);
      end
    end
  endtask

  task automatic test_registered;
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; X = 32'h0000FFFF; S = 5'd15;
    @(posedge clk); #1;
    S = 5'd16;
    asserts++;
    if (Y_q !== 1'b1) begin fails++; $display("FAIL reg_s15_yq: got %b expected 1", Y_q); end
    asserts++;
    if (valid_q !== 1'b1) begin fails++; $display("FAIL reg_s15_valid: got %b expected 1", valid_q); end
    @(posedge clk); #1;
    asserts++;
    if (Y_q !== 1'b0) begin fails++; $display("FAIL reg_s16_yq: got %b expected 0", Y_q); end
    asserts++;
    if (valid_q !== 1'b1) begin fails++; $display("FAIL reg_s16_valid: got %b expected 1", valid_q); end
  endtask

  task automatic test_hold_reset;
    @(negedge clk);
    S = 5'd15;
    @(posedge clk); #1;
    asserts++;
    if (Y_q !== 1'b1) begin fails++; $display("FAIL hold_setup_yq: got %b expected 1", Y_q); end
    en = 1'b0; X = 32'h0;
    @(posedge clk); #1;
    asserts++;
    if (Y_q !== 1'b1) begin fails++; $display("FAIL hold_yq: got %b expected 1", Y_q); end
    asserts++;
    if (valid_q !== 1'b0) begin fails++; $display("FAIL hold_valid: got %b expected 0", valid_q); end
    X = 32'h00008000; en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    asserts++;
    if (Y_q !== 1'b0) begin fails++; $display("FAIL async_reset_yq: got %b expected 0", Y_q); end
    asserts++;
    if (valid_q !== 1'b0) begin fails++; $display("FAIL async_reset_valid: got %b expected 0", valid_q); end
    asserts++;
    if (Y !== 1'b1) begin fails++; $display("FAIL reset_comb_y: got %b expected 1", Y); end
    // Reset must override en across an edge.
    @(posedge clk); #1;
    asserts++;
    if (Y_q !== 1'b0 || valid_q !== 1'b0) begin
      fails++; $display("FAIL reset_over_en: got Y_q=%b valid_q=%b expected 0 0", Y_q, valid_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random;
    logic exp_yq;
    logic exp_vld;
    int   s;
    exp_yq  = 1'b0;
    exp_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; #1; rst_n = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      X  = $urandom;
      s  = $urandom_range(31, 0);
      S  = s[4:0];
      en = ($urandom_range(3, 0) != 0);
      #1;
      asserts++;
      if (Y !== ref_sel(X, s)) begin
        fails++; $display("FAIL rand_comb c=%0d: got %b expected %b", c, Y, ref_sel(X, s));
      end
      if (en) exp_yq = ref_sel(X, s);
      exp_vld = en;
      @(posedge clk); #1;
      asserts++;
      if (Y_q !== exp_yq || valid_q !== exp_vld) begin
        fails++;
        $display("FAIL rand_reg c=%0d: got Y_q=%b valid_q=%b expected %b %b", c, Y_q, valid_q, exp_yq, exp_vld);
      end
    end
  endtask

  initial begin
    asserts = 0;
    fails   = 0;
    test_reset();
    test_alternating();
    test_walking_one();
    test_boundary();
    test_registered();
    test_hold_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
